regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (ALU) and port 1 (load unit).
- Grants one write per cycle using 2-way round-robin, then drives a registered write command (we/waddr/wdata) to the regfile.
- Holds a per-register busy scoreboard, set at issue and cleared when the write commits. ID uses it to stall on RAW hazards.

Parameters:
- RADDR_WIDTH, 5, register address width
- RDATA_WIDTH, 32, register data width
- RNUM, 32, number of architectural registers

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- wb0_valid_i  in  1  port 0 write request
- wb0_ready_o  out  1  port 0 request accepted this cycle
- wb0_addr_i  in  RADDR_WIDTH  port 0 destination register
- wb0_data_i  in  RDATA_WIDTH  port 0 write data
- wb1_valid_i, wb1_ready_o, wb1_addr_i, wb1_data_i: same as port 0, for port 1
- issue_valid_i  in  1  an instruction with a destination register issues this cycle
- issue_addr_i  in  RADDR_WIDTH  its destination register
- chk_addr1_i  in  RADDR_WIDTH  hazard query address 1 (rs1)
- chk_addr2_i  in  RADDR_WIDTH  hazard query address 2 (rs2)
- busy1_o  out  1  register chk_addr1_i has a write pending (combinational)
- busy2_o  out  1  register chk_addr2_i has a write pending (combinational)
- we_o  out  1  regfile write enable (registered)
- waddr_o  out  RADDR_WIDTH  regfile write address (registered)
- wdata_o  out  RDATA_WIDTH  regfile write data (registered)

Behaviour:
- Reset (rst_i low, asynchronous):
  - we_o=0, waddr_o=0, wdata_o=0.
  - All busy bits cleared.
  - Round-robin pointer set so port 0 has priority.
  - Ready outputs are combinational and are 0 while in reset.
- Handshake: a transfer happens on a rising edge where valid&ready=1.
  - A requester must hold valid, addr and data stable until it sees ready.
  - ready is combinational from both valids and the pointer. It never depends on its own port's addr/data.
- Arbitration:
  - Only one port valid: that port gets ready=1.
  - Both ports valid: the priority port gets ready=1 and the other gets 0. After the grant, the pointer moves to the other port.
  - Neither port valid: both ready=0 and the pointer is held.
- Output register: the output stage drains every cycle, so there is no backpressure from the regfile.
  - A transfer at edge N drives we_o=1 with that addr/data for the cycle after edge N. The regfile captures it at edge N+1.
  - No transfer at edge N gives we_o=0 in the following cycle. waddr_o/wdata_o hold their previous values.
- x0 writes: transfer addr==0 is accepted (ready=1 as normal) but produces we_o=0. This is the only gating; no scoreboard effect.
- Scoreboard, set:
  - At an edge with issue_valid_i=1 and issue_addr_i!=0, busy[issue_addr_i] is set to 1.
  - A second issue to an already-busy register is legal; the bit stays 1.
- Scoreboard, clear:
  - At an edge with we_o=1, busy[waddr_o] is cleared. This is the same edge at which the regfile captures the data.
  - The data is therefore readable from the regfile in the same cycle the busy bit drops.
- Set and clear of the same register at the same edge: set wins and the bit stays 1.
- busy1_o = busy[chk_addr1_i], busy2_o = busy[chk_addr2_i]. Both are forced to 0 when the query address is 0.
- Latency: accept to regfile-visible and busy-clear takes 2 edges. Worst case for a denied requester under continuous contention is 1 extra cycle.
- Reset asserted mid-operation: any pending output write is dropped (we_o=0) and all busy bits are cleared. Issue of the pipeline flush is the pipeline's responsibility.

Decomposition:
- Shared defines file (defines.v) holds RADDR_WIDTH, RDATA_WIDTH, RNUM, ZERO_REG, ZERO, WRITE_ENABLE and WRITE_DISABLE. RNUM width rules come from there.
- One sub-module: rr_arb2, a 2-input round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0], one-hot or zero.
  - State: the pointer flop, reset to port-0 priority.
- Scoreboard (RNUM-bit vector) and the output register stay in the top module.

Test Plan:
- Reset then single write: wb0 valid, addr 5, data 0xDEADBEEF for one cycle -> wb0_ready=1. Next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF. Following cycle we_o=0.
- Contention: wb0 and wb1 both valid for 4 cycles (addrs 1/2, distinct data) -> grants alternate 0,1,0,1. Each grant appears on we_o one cycle later, in the same order.
- Scoreboard round trip: issue addr 7 -> busy1_o=1 with chk_addr1=7. wb1 writes addr 7 -> busy1_o stays 1 through the accept cycle and drops to 0 after the edge where we_o=1 commits.
- Same-edge set/clear: we_o=1 with waddr_o=9 while issue_valid_i=1, issue_addr_i=9 -> busy[9] remains 1.
- x0 handling: issue addr 0 and wb0 write addr 0 -> ready=1, we_o stays 0, busy query on addr 0 returns 0.
- Async reset mid-flight: busy[3]=1 and we_o=1 pending, then assert rst_i low between edges -> we_o, waddr_o and wdata_o go to 0 and busy[3] goes to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, constants and types for the register-file writeback arbiter.
// Stands in for the old defines.v so every file picks them up via import.
package regfile_wb_arbiter_pkg;

  localparam int RADDR_WIDTH_DEF = 5;
  localparam int RDATA_WIDTH_DEF = 32;
  localparam int RNUM_DEF        = 32;

  localparam int   ZERO_REG      = 0;
  localparam int   ZERO          = 0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Which requester wins when both ask in the same cycle
  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: grant is combinational from the requests and
// the priority pointer, and the pointer flips to the loser after each grant.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  prio_e prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == PRIO_P0) ? 2'b01 : 2'b10;
    end
  end

  // After serving a port, the other one becomes the favoured requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_P0;
    end else if (advance && (gnt != 2'b00)) begin
      prio <= gnt[0] ? PRIO_P1 : PRIO_P0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between the ALU and load-unit writeback
// paths, and tracks pending writes per register for the ID hazard check.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int RADDR_WIDTH = RADDR_WIDTH_DEF,
  parameter int RDATA_WIDTH = RDATA_WIDTH_DEF,
  parameter int RNUM        = RNUM_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb0_valid_i,
  output logic                   wb0_ready_o,
  input  logic [RADDR_WIDTH-1:0] wb0_addr_i,
  input  logic [RDATA_WIDTH-1:0] wb0_data_i,
  input  logic                   wb1_valid_i,
  output logic                   wb1_ready_o,
  input  logic [RADDR_WIDTH-1:0] wb1_addr_i,
  input  logic [RDATA_WIDTH-1:0] wb1_data_i,
  input  logic                   issue_valid_i,
  input  logic [RADDR_WIDTH-1:0] issue_addr_i,
  input  logic [RADDR_WIDTH-1:0] chk_addr1_i,
  input  logic [RADDR_WIDTH-1:0] chk_addr2_i,
  output logic                   busy1_o,
  output logic                   busy2_o,
  output logic                   we_o,
  output logic [RADDR_WIDTH-1:0] waddr_o,
  output logic [RDATA_WIDTH-1:0] wdata_o
);

  localparam logic [RADDR_WIDTH-1:0] ZERO_ADDR = RADDR_WIDTH'(ZERO_REG);

  logic [1:0]             gnt;
  logic                   xfer;
  logic [RADDR_WIDTH-1:0] sel_addr;
  logic [RDATA_WIDTH-1:0] sel_data;
  logic [RNUM-1:0]        busy;
  logic [RNUM-1:0]        busy_nxt;

  rr_arb2 u_arb (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .req     ({wb1_valid_i, wb0_valid_i}),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Readies are the grants, held low while reset is asserted
  assign wb0_ready_o = gnt[0] & rst_i;
  assign wb1_ready_o = gnt[1] & rst_i;
  assign xfer        = wb0_ready_o | wb1_ready_o;

  assign sel_addr = gnt[1] ? wb1_addr_i : wb0_addr_i;
  assign sel_data = gnt[1] ? wb1_data_i : wb0_data_i;

  // Output stage drains every cycle; x0 transfers are accepted but never written
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_o    <= WRITE_DISABLE;
      waddr_o <= '0;
      wdata_o <= RDATA_WIDTH'(ZERO);
    end else begin
      we_o <= (xfer && (sel_addr != ZERO_ADDR)) ? WRITE_ENABLE : WRITE_DISABLE;
      if (xfer) begin
        waddr_o <= sel_addr;
        wdata_o <= sel_data;
      end
    end
  end

  // Clear on commit, then set on issue, so a same-edge set keeps the bit high
  always_comb begin
    busy_nxt = busy;
    if (we_o) begin
      busy_nxt[waddr_o] = 1'b0;
    end
    if (issue_valid_i && (issue_addr_i != ZERO_ADDR)) begin
      busy_nxt[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy1_o = (chk_addr1_i != ZERO_ADDR) && busy[chk_addr1_i];
  assign busy2_o = (chk_addr2_i != ZERO_ADDR) && busy[chk_addr2_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: handshake, round-robin,
// scoreboard set/clear, x0 gating and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        wb0_valid_i = 1'b0;
  logic        wb0_ready_o;
  logic [4:0]  wb0_addr_i = '0;
  logic [31:0] wb0_data_i = '0;
  logic        wb1_valid_i = 1'b0;
  logic        wb1_ready_o;
  logic [4:0]  wb1_addr_i = '0;
  logic [31:0] wb1_data_i = '0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_addr_i = '0;
  logic [4:0]  chk_addr1_i = '0;
  logic [4:0]  chk_addr2_i = '0;
  logic        busy1_o;
  logic        busy2_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wb0_valid_i   (wb0_valid_i),
    .wb0_ready_o   (wb0_ready_o),
    .wb0_addr_i    (wb0_addr_i),
    .wb0_data_i    (wb0_data_i),
    .wb1_valid_i   (wb1_valid_i),
    .wb1_ready_o   (wb1_ready_o),
    .wb1_addr_i    (wb1_addr_i),
    .wb1_data_i    (wb1_data_i),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .chk_addr1_i   (chk_addr1_i),
    .chk_addr2_i   (chk_addr2_i),
    .busy1_o       (busy1_o),
    .busy2_o       (busy2_o),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .wdata_o       (wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    issue_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    wb0_valid_i = 1'b1;
    wb1_valid_i = 1'b1;
    chk_addr1_i = 5'd5;
    #2;
    vectors++;
    if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: we=%b waddr=%0d wdata=%h, want 0/0/0", we_o, waddr_o, wdata_o);
    end
    vectors++;
    if (wb0_ready_o !== 1'b0 || wb1_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: r0=%b r1=%b, want 0/0", wb0_ready_o, wb1_ready_o);
    end
    vectors++;
    if (busy1_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: busy1=%b, want 0", busy1_o);
    end
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_single_write();
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd5;
    wb0_data_i  = 32'hDEADBEEF;
    #1;
    vectors++;
    if (wb0_ready_o !== 1'b1 || wb1_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_ready: r0=%b r1=%b, want 1/0", wb0_ready_o, wb1_ready_o);
    end
    tick();
    wb0_valid_i = 1'b0;
    vectors++;
    if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL single_cmd: we=%b waddr=%0d wdata=%h, want 1/5/deadbeef", we_o, waddr_o, wdata_o);
    end
    tick();
    vectors++;
    if (we_o !== 1'b0 || waddr_o !== 5'd5 || wdata_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL single_idle: we=%b waddr=%0d wdata=%h, want 0/5/deadbeef", we_o, waddr_o, wdata_o);
    end
  endtask

  task automatic test_contention();
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    int          p;
    do_reset();
    d0 = 32'hA000_0000;
    d1 = 32'hB000_0000;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd1;
    wb0_data_i  = d0;
    wb1_valid_i = 1'b1;
    wb1_addr_i  = 5'd2;
    wb1_data_i  = d1;
    #1;
    for (int i = 0; i < 4; i++) begin
      p = i % 2;
      vectors++;
      if (wb0_ready_o !== (p == 0) || wb1_ready_o !== (p == 1)) begin
        miscompares++;
        $display("[TB] FAIL rr_grant[%0d]: r0=%b r1=%b, want port %0d", i, wb0_ready_o, wb1_ready_o, p);
      end
      exp_addr = (p == 1) ? 5'd2 : 5'd1;
      exp_data = (p == 1) ? d1 : d0;
      tick();
      vectors++;
      if (we_o !== 1'b1 || waddr_o !== exp_addr || wdata_o !== exp_data) begin
        miscompares++;
        $display("[TB] FAIL rr_cmd[%0d]: we=%b waddr=%0d wdata=%h, want 1/%0d/%h", i, we_o, waddr_o, wdata_o, exp_addr, exp_data);
      end
      if (p == 0) begin
        d0 = d0 + 1;
        wb0_data_i = d0;
      end else begin
        d1 = d1 + 1;
        wb1_data_i = d1;
      end
      #1;
    end
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    tick();
    vectors++;
    if (we_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_drain: we=%b, want 0", we_o);
    end
  endtask

  task automatic test_scoreboard();
    chk_addr1_i = 5'd7;
    chk_addr2_i = 5'd7;
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd7;
    #1;
    vectors++;
    if (busy1_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_pre_issue: busy1=%b, want 0", busy1_o);
    end
    tick();
    issue_valid_i = 1'b0;
    vectors++;
    if (busy1_o !== 1'b1 || busy2_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_set: busy1=%b busy2=%b, want 1/1", busy1_o, busy2_o);
    end
    wb1_valid_i = 1'b1;
    wb1_addr_i  = 5'd7;
    wb1_data_i  = 32'h0000_0077;
    #1;
    vectors++;
    if (wb1_ready_o !== 1'b1 || busy1_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_accept: r1=%b busy1=%b, want 1/1", wb1_ready_o, busy1_o);
    end
    tick();
    wb1_valid_i = 1'b0;
    vectors++;
    if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'h77 || busy1_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_commit_cycle: we=%b waddr=%0d wdata=%h busy1=%b, want 1/7/77/1", we_o, waddr_o, wdata_o, busy1_o);
    end
    tick();
    vectors++;
    if (busy1_o !== 1'b0 || busy2_o !== 1'b0 || we_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_clear: busy1=%b busy2=%b we=%b, want 0/0/0", busy1_o, busy2_o, we_o);
    end
  endtask

  task automatic test_same_edge();
    chk_addr1_i = 5'd9;
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd9;
    tick();
    issue_valid_i = 1'b0;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd9;
    wb0_data_i  = 32'h0000_0999;
    tick();
    wb0_valid_i = 1'b0;
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd9;
    vectors++;
    if (we_o !== 1'b1 || waddr_o !== 5'd9) begin
      miscompares++;
      $display("[TB] FAIL same_edge_cmd: we=%b waddr=%0d, want 1/9", we_o, waddr_o);
    end
    tick();
    issue_valid_i = 1'b0;
    vectors++;
    if (busy1_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL same_edge_busy: busy1=%b, want 1", busy1_o);
    end
    tick();
    vectors++;
    if (busy1_o !== 1'b1 || we_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL same_edge_hold: busy1=%b we=%b, want 1/0", busy1_o, we_o);
    end
  endtask

  task automatic test_x0();
    chk_addr1_i = 5'd0;
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd0;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd0;
    wb0_data_i  = 32'h0000_1234;
    #1;
    vectors++;
    if (wb0_ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL x0_ready: r0=%b, want 1", wb0_ready_o);
    end
    tick();
    issue_valid_i = 1'b0;
    wb0_valid_i = 1'b0;
    vectors++;
    if (we_o !== 1'b0 || busy1_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL x0_gate: we=%b busy1=%b, want 0/0", we_o, busy1_o);
    end
  endtask

  task automatic test_async_reset();
    chk_addr1_i = 5'd3;
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd3;
    tick();
    issue_valid_i = 1'b0;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd3;
    wb0_data_i  = 32'h0000_CAFE;
    tick();
    vectors++;
    if (we_o !== 1'b1 || busy1_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL arst_pending: we=%b busy1=%b, want 1/1", we_o, busy1_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    vectors++;
    if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL arst_outputs: we=%b waddr=%0d wdata=%h, want 0/0/0", we_o, waddr_o, wdata_o);
    end
    vectors++;
    if (busy1_o !== 1'b0 || wb0_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL arst_busy_ready: busy1=%b r0=%b, want 0/0", busy1_o, wb0_ready_o);
    end
    wb0_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_same_edge();
    test_x0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
